// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-save accumulator controller.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } csa_state_e;

  localparam int IN_W_DEF  = 12;
  localparam int ACC_W_DEF = 15;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/csa_3to2_w.sv
// Combinational W-bit 3:2 carry-save compressor; the carry output is already
// shifted left one place with the bit leaving the MSB discarded.
module csa_3to2_w #(
  parameter int W = 15
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] maj_s;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj_s   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = maj_s << 1;

endmodule

// File: rtl/csa_accum_seq.sv
// Carry-save group accumulator with a single carry-propagate resolve per group.
// Define CSA_ACC_OVF_EN to add the sticky overflow flag and the out_ovf port.
module csa_accum_seq
  import csa_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef CSA_ACC_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  csa_state_e       state_q;
  logic [ACC_W-1:0] s_q, cy_q, s_d, cy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic [ACC_W-1:0] x_s;
  logic             accept_s;

  assign x_s       = ACC_W'(in_data);
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign accept_s  = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  csa_3to2_w #(.W(ACC_W)) u_csa (
    .a_i    (s_q),
    .b_i    (cy_q),
    .c_i    (x_s),
    .sum_o  (s_d),
    .carry_o(cy_d)
  );

`ifdef CSA_ACC_OVF_EN
  logic             ovf_q, out_ovf_q;
  logic             maj_msb_s;
  logic [ACC_W:0]   total_s;
  assign maj_msb_s = (s_q[ACC_W-1] & cy_q[ACC_W-1]) | (s_q[ACC_W-1] & x_s[ACC_W-1])
                   | (cy_q[ACC_W-1] & x_s[ACC_W-1]);
  assign total_s   = {1'b0, s_q} + {1'b0, cy_q};
  assign out_ovf   = out_ovf_q;
`else
  logic [ACC_W-1:0] total_s;
  assign total_s   = s_q + cy_q;
`endif

  // Controller: state, redundant accumulator, counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      s_q         <= '0;
      cy_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef CSA_ACC_OVF_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACC: begin
          if (accept_s) begin
            s_q  <= s_d;
            cy_q <= cy_d;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
`ifdef CSA_ACC_OVF_EN
            if (maj_msb_s) ovf_q <= 1'b1;
`endif
            if (in_last) state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_data_q  <= total_s[ACC_W-1:0];
          out_count_q <= cnt_q;
`ifdef CSA_ACC_OVF_EN
          ovf_q       <= ovf_q | total_s[ACC_W];
          out_ovf_q   <= ovf_q | total_s[ACC_W];
`endif
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            s_q     <= '0;
            cy_q    <= '0;
            cnt_q   <= '0;
`ifdef CSA_ACC_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_csa_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [11:0] in_data;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [14:0] out_data, out_data2;
  logic [7:0]  out_count;
  logic [1:0]  out_count2;
`ifdef CSA_ACC_OVF_EN
  logic        out_ovf, out_ovf2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_accum_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
`ifdef CSA_ACC_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  csa_accum_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2)
`ifdef CSA_ACC_OVF_EN
    , .out_ovf(out_ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one operand at a falling edge; it is taken at the next rising edge.
  task automatic send(input logic [11:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 12'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
`ifdef CSA_ACC_OVF_EN
    chk("rst_out_ovf", out_ovf, 0);
`endif
    rst = 1'b0;

    // 5 + 7 + 9
    out_ready = 1'b1;
    send(12'd5, 1'b0);
    send(12'd7, 1'b0);
    send(12'd9, 1'b1);
    chk("t1_valid_resolve", out_valid, 0);
    chk("t1_ready_resolve", in_ready, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 21);
    chk("t1_count", out_count, 3);
    @(negedge clk);
    chk("t1_ready_back", in_ready, 1);
    chk("t1_valid_drop", out_valid, 0);

    // single operand group
    send(12'd4095, 1'b1);
    @(negedge clk);
    chk("t2_data", out_data, 4095);
    chk("t2_count", out_count, 1);
`ifdef CSA_ACC_OVF_EN
    chk("t2_ovf", out_ovf, 0);
`endif
    @(negedge clk);

    // ten operands of 4095: 40950 mod 32768
    for (int i = 0; i < 10; i++) send(12'd4095, (i == 9));
    @(negedge clk);
    chk("t3_data", out_data, 8182);
    chk("t3_count", out_count, 10);
    chk("t3_count_sat", out_count2, 3);
`ifdef CSA_ACC_OVF_EN
    chk("t3_ovf", out_ovf, 1);
`endif
    @(negedge clk);

    // consumer stalls for three cycles while a new operand is offered
    out_ready = 1'b0;
    send(12'd3, 1'b0);
    send(12'd4, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'd100; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_data", out_data, 7);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release", in_ready, 1);
    send(12'd6, 1'b1);
    @(negedge clk);
    chk("t4_next_data", out_data, 6);
    chk("t4_next_count", out_count, 1);
    @(negedge clk);

    // reset in the middle of a group
    send(12'd1, 1'b0);
    send(12'd2, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(12'd3, 1'b0);
    send(12'd4, 1'b1);
    @(negedge clk);
    chk("t5_data", out_data, 7);
    chk("t5_count", out_count, 2);
`ifdef CSA_ACC_OVF_EN
    chk("t5_ovf", out_ovf, 0);
`endif
    @(negedge clk);

    // six ones: narrow counter saturates at 3
    for (int i = 0; i < 6; i++) send(12'd1, (i == 5));
    @(negedge clk);
    chk("t6_count_sat", out_count2, 3);
    chk("t6_data_sat", out_data2, 6);
    chk("t6_count", out_count, 6);
    chk("t6_valid", out_valid2, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_accum_seq.md
# csa_accum_seq

Sequenced carry-save accumulator controller. Accepts a stream of unsigned operands over a valid/ready handshake and folds each one into a redundant sum/carry pair through a 3:2 carry-save compressor, one operand per cycle, with no carry propagation in the loop. When a group ends, the block performs one carry-propagate resolve and presents the binary total downstream. It sits between operand producers (partial-product or MAC lanes) and result consumers in the GEMV datapath.

## Interface
- `IN_W`, 12: operand width in bits.
- `ACC_W`, 15: accumulator, sum/carry vector and result width; must be ≥ `IN_W`.
- `CNT_W`, 8: width of the operand counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block accepts an operand this cycle.
- `in_data`  in  `IN_W`  unsigned operand, zero-extended to `ACC_W`.
- `in_last`  in  1  qualifies the accepted operand as the final operand of its group.
- `out_valid`  out  1  result held on `out_data`.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  `ACC_W`  group sum modulo 2^`ACC_W`.
- `out_count`  out  `CNT_W`  number of operands in the group, saturating.
- `out_ovf`  out  1  present only with `CSA_ACC_OVF_EN`; see Configuration.

## Operation
- States: `ACC`, `RESOLVE`, `OUT`. Reset state is `ACC`.
- Accept condition: `in_valid && in_ready`. `in_ready` is 1 only in `ACC`.
- `ACC`:
  - On each accept: `S <= S ^ Cy ^ X`; `Cy <= (maj(S, Cy, X) << 1)` truncated to `ACC_W`. `X` is the zero-extended `in_data`.
  - `cnt` increments and saturates at 2^`CNT_W`−1.
  - An accept with `in_last` = 1 moves to `RESOLVE`.
  - With no accept, the state holds.
- `RESOLVE`, one cycle: `out_data <= S + Cy` (mod 2^`ACC_W`); `out_count <= cnt`. Move to `OUT`.
- `OUT`:
  - `out_valid` = 1 and `out_data`/`out_count` are stable.
  - On `out_ready`: clear `S`, `Cy` and `cnt` to 0, then return to `ACC`.
  - Without `out_ready`, the state holds indefinitely.
- `in_last` is ignored unless an accept occurs.
- A group of one operand is legal.
- The result is always modulo 2^`ACC_W`. Bits shifted out of the MSB of `Cy` are discarded.

## Timing
- Throughput: one operand per cycle in `ACC`.
- Latency: last operand accepted at edge t → `out_valid` rises after edge t+1 (end of `RESOLVE`) and is visible in the cycle after it.
- Minimum group turnaround: last accept, `RESOLVE`, and one `OUT` cycle with `out_ready` = 1, giving 3 cycles before the next accept.
- `in_ready` is low from the cycle after the last accept until the cycle after the `OUT` handshake.
- All outputs are registered. `in_ready` is decoded directly from the state register.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0. `S`, `Cy` and `cnt` reset to 0.
- Reset mid-group or mid-`OUT` discards everything immediately, asynchronously. The first edge after reset release may accept an operand.

## Configuration
- `CSA_ACC_OVF_EN` defined:
  - Adds port `out_ovf` and a sticky `ovf` register.
  - `ovf` sets when an accept drops a 1 from the MSB of the majority vector, or when the `RESOLVE` add carries out of bit `ACC_W`−1.
  - `out_ovf` loads from `ovf` in `RESOLVE`. `ovf` clears together with `S`/`Cy`.
  - `out_ovf` = 1 exactly when the true group sum is ≥ 2^`ACC_W`.
- `CSA_ACC_OVF_EN` undefined: no port and no register. Behaviour is otherwise identical.

## Structure
- Shared package `csa_pkg`: the state enum (`ACC`, `RESOLVE`, `OUT`) and default width constants.
- One sub-module: `csa_3to2_w`, a purely combinational parameterized `ACC_W`-wide 3:2 compressor with outputs sum and shifted carry. It is instantiated once; the controller holds all registers.

## Test plan
- Operands 5, 7, 9 (last on 9), `out_ready` held 1 → `out_data`=21, `out_count`=3, `out_valid` visible 2 cycles after accepting 9.
- Single operand 4095 with `in_last` → `out_data`=4095, `out_count`=1, `out_ovf`=0.
- Ten operands of 4095 (defaults, macro on) → `out_data`=8182, `out_ovf`=1, `out_count`=10.
- `out_ready` low for 3 cycles in `OUT` → `out_data` stable, `in_ready`=0, and an offered `in_valid` is not consumed. The next group then starts from 0.
- Reset asserted after 2 of 4 operands, with a new group of 3 and 4 after release → `out_data`=7, `out_count`=2.
- `CNT_W`=2, six operands of 1 → `out_count`=3 (saturated), `out_data`=6.
